// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio clip player.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package audio_pkg;

  // Fetch sequencer states: wait for a tick, present the ROM address,
  // ride out the ROM latency, then hold the latched sample until the next tick.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Ceiling log2 with a floor of 1 so single-entry fields still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Unsigned mid-scale code: the silent level that avoids a pop.
  function automatic int midscale(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/audio_clip_player_pwm_dac.sv
// PWM DAC: free-running SAMPLE_W-bit ramp compared against a level latched at wrap.
// Latency: a new level appears on pwm_out at the start of the next PWM period.
// Backpressure: none; level is sampled only at counter wrap.
//
// Ports: clk, system_reset (async, active-high), level (sample to reproduce),
//        pwm_out (duty = level / 2^SAMPLE_W).
module pwm_dac
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                system_reset,
  input  logic [SAMPLE_W-1:0] level,
  output logic                pwm_out
);

  logic [SAMPLE_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] level_q, level_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    // Reload only on the last count so a period never mixes two levels.
    level_d = (cnt_q == '1) ? level : level_q;
  end

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      cnt_q   <= '0;
      level_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign pwm_out = (cnt_q < level_q);

endmodule

// File: rtl/audio_clip_player.sv
// Multi-channel clip player: fixed-priority arbitration, one ROM fetch per sample tick, PWM out.
// Latency: sample_out/sample_valid update ROM_LAT+2 cycles after the tick cycle.
// Backpressure: none; requests are levels, ROM has fixed latency, output is a pulse.
//
// Ports: clk, system_reset (async, active-high); ch_req/ch_loop/ch_base/ch_len per-channel
//        clip control; rom_addr/rom_data shared sample ROM; sample_out/sample_valid current
//        sample; active_ch/busy/ch_done status; pwm_out audio output.
module audio_clip_player
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int SAMPLE_HZ = 8000,
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 16,
  parameter int SAMPLE_W  = 8,
  parameter int ROM_LAT   = 1,
  localparam int CH_W     = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     system_reset,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_loop,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_len,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [SAMPLE_W-1:0]      rom_data,
  output logic [SAMPLE_W-1:0]      sample_out,
  output logic                     sample_valid,
  output logic [CH_W-1:0]          active_ch,
  output logic                     busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     pwm_out
);

  localparam int                   DIV       = CLK_HZ / SAMPLE_HZ;
  localparam int                   CNT_W     = clog2(DIV);
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [1:0]           WAIT_LAST = 2'(ROM_LAT - 1);
  localparam logic [SAMPLE_W-1:0]  MID       = SAMPLE_W'(midscale(SAMPLE_W));

  // Sample-rate divider
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Fixed-priority arbiter: lowest eligible index wins.
  logic [NUM_CH-1:0] elig;
  logic              win_vld;
  logic [CH_W-1:0]   win;
  logic [NUM_CH-1:0] latch_q, latch_d;

  always_comb begin
    elig    = '0;
    win_vld = 1'b0;
    win     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      elig[i] = ch_req[i] && (ch_len[i*ADDR_W +: ADDR_W] != '0) && !latch_q[i];
      if (elig[i]) begin
        win_vld = 1'b1;
        win     = CH_W'(i);
      end
    end
  end

  logic [ADDR_W-1:0] win_base, win_len;
  logic              win_loop;

  assign win_base = ch_base[int'(win)*ADDR_W +: ADDR_W];
  assign win_len  = ch_len[int'(win)*ADDR_W +: ADDR_W];
  assign win_loop = ch_loop[win];

  // Fetch sequencer
  state_t              state_q, state_d;
  logic [1:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic                loop_q, loop_d;
  logic [CH_W-1:0]     act_q, act_d;
  logic [SAMPLE_W-1:0] smp_q, smp_d;
  logic                vld_q, vld_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [ADDR_W-1:0]   start_off;
  logic [ADDR_W:0]     off_nxt;
  logic                last;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    offset_d   = offset_q;
    rom_addr_d = rom_addr_q;
    len_d      = len_q;
    loop_d     = loop_q;
    act_d      = act_q;
    smp_d      = smp_q;
    vld_d      = 1'b0;
    pend_d     = '0;
    done_d     = pend_q;
    start_off  = '0;
    // Dropping a request re-arms its one-shot channel.
    latch_d    = latch_q & ch_req;
    // Compare with a carry bit so offset+1 never wraps; also catches a length
    // shrunk below the current position.
    off_nxt    = {1'b0, offset_q} + 1'b1;
    last       = (off_nxt >= {1'b0, len_q});

    case (state_q)
      IDLE, LATCH: begin
        if (tick) begin
          if (win_vld) begin
            // New winner or coming out of idle restarts the clip.
            start_off  = ((state_q == IDLE) || (win != act_q)) ? '0 : offset_q;
            offset_d   = start_off;
            rom_addr_d = win_base + start_off;
            len_d      = win_len;
            loop_d     = win_loop;
            act_d      = win;
            state_d    = ADDR;
          end else begin
            state_d = IDLE;
            if (smp_q != MID) begin
              smp_d = MID;
              vld_d = 1'b1;
            end
          end
        end
      end
      ADDR: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = LATCH;
          smp_d   = rom_data;
          vld_d   = 1'b1;
          if (last) begin
            offset_d = '0;
            if (!loop_q) begin
              latch_d[act_q] = 1'b1;
              pend_d[act_q]  = 1'b1;
            end
          end else begin
            offset_d = off_nxt[ADDR_W-1:0];
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      cnt_q      <= '0;
      state_q    <= IDLE;
      wait_q     <= '0;
      offset_q   <= '0;
      rom_addr_q <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      act_q      <= '0;
      smp_q      <= MID;
      vld_q      <= 1'b0;
      latch_q    <= '0;
      pend_q     <= '0;
      done_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      wait_q     <= wait_d;
      offset_q   <= offset_d;
      rom_addr_q <= rom_addr_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      act_q      <= act_d;
      smp_q      <= smp_d;
      vld_q      <= vld_d;
      latch_q    <= latch_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sample_out   = smp_q;
  assign sample_valid = vld_q;
  assign active_ch    = act_q;
  assign busy         = (state_q != IDLE);
  assign ch_done      = done_q;

  pwm_dac #(
    .SAMPLE_W(SAMPLE_W)
  ) u_pwm (
    .clk         (clk),
    .system_reset(system_reset),
    .level       (smp_q),
    .pwm_out     (pwm_out)
  );

endmodule

// File: tb/tb_audio_clip_player.sv
// Directed bench for audio_clip_player: per-tick vector table plus reset and PWM sequences.
// Latency: checks rom_addr at tick+1, sample at tick+3, ch_done at tick+4 (in cycles).
// Backpressure: n/a.
module tb_audio_clip_player;

  localparam int DIV = 10;

  logic        clk;
  logic        system_reset;
  logic [1:0]  ch_req;
  logic [1:0]  ch_loop;
  logic [31:0] ch_base;
  logic [31:0] ch_len;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic [0:0]  active_ch;
  logic        busy;
  logic [1:0]  ch_done;
  logic        pwm_out;

  audio_clip_player #(
    .CLK_HZ   (80000),
    .SAMPLE_HZ(8000),
    .NUM_CH   (2),
    .ADDR_W   (16),
    .SAMPLE_W (8),
    .ROM_LAT  (1)
  ) dut (
    .clk         (clk),
    .system_reset(system_reset),
    .ch_req      (ch_req),
    .ch_loop     (ch_loop),
    .ch_base     (ch_base),
    .ch_len      (ch_len),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .active_ch   (active_ch),
    .busy        (busy),
    .ch_done     (ch_done),
    .pwm_out     (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM[a] = a (low byte), one cycle of read latency.
  always @(posedge clk) rom_data <= rom_addr[7:0];

  int n_vec = 0;
  int n_bad = 0;
  int ph    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ph mirrors the divider count after each rising edge (0 right after the tick edge).
  task automatic edge1();
    @(posedge clk);
    ph = (ph + 1) % DIV;
  endtask

  task automatic to_tick();
    do edge1(); while (ph != 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rom_addr"}, rom_addr, 32'h0);
    chk({tag, " sample_out"}, sample_out, 32'h80);
    chk({tag, " sample_valid"}, sample_valid, 32'h0);
    chk({tag, " active_ch"}, active_ch, 32'h0);
    chk({tag, " busy"}, busy, 32'h0);
    chk({tag, " ch_done"}, ch_done, 32'h0);
    chk({tag, " pwm_out"}, pwm_out, 32'h0);
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  loop;
    logic [15:0] base0;
    logic [15:0] len0;
    logic [15:0] len1;
    logic        fetch;   // expect a ROM fetch this tick
    logic [15:0] addr;
    logic        act;
    logic        v0;      // sample_valid right after the tick edge (return to mid-scale)
    logic [7:0]  smp;
    logic [1:0]  done;
  } vec_t;

  function automatic vec_t fv(logic [1:0] req, logic [1:0] loop, logic [15:0] base0,
                              logic [15:0] len0, logic [15:0] len1, logic [15:0] addr,
                              logic act, logic [7:0] smp, logic [1:0] done);
    vec_t v;
    v.req = req; v.loop = loop; v.base0 = base0; v.len0 = len0; v.len1 = len1;
    v.fetch = 1'b1; v.addr = addr; v.act = act; v.v0 = 1'b0; v.smp = smp; v.done = done;
    return v;
  endfunction

  function automatic vec_t iv(logic [1:0] req, logic [1:0] loop, logic [15:0] base0,
                              logic [15:0] len0, logic [15:0] len1, logic v0);
    vec_t v;
    v.req = req; v.loop = loop; v.base0 = base0; v.len0 = len0; v.len1 = len1;
    v.fetch = 1'b0; v.addr = '0; v.act = 1'b0; v.v0 = v0; v.smp = 8'h80; v.done = 2'b00;
    return v;
  endfunction

  vec_t vt[28];
  int   hi;
  logic found, prev;

  initial begin
    // Looping channel 0, length 3
    vt[0]  = fv(2'b01, 2'b01, 16'h0010, 3, 0, 16'h0010, 0, 8'h10, 2'b00);
    vt[1]  = fv(2'b01, 2'b01, 16'h0010, 3, 0, 16'h0011, 0, 8'h11, 2'b00);
    vt[2]  = fv(2'b01, 2'b01, 16'h0010, 3, 0, 16'h0012, 0, 8'h12, 2'b00);
    vt[3]  = fv(2'b01, 2'b01, 16'h0010, 3, 0, 16'h0010, 0, 8'h10, 2'b00);
    vt[4]  = iv(2'b00, 2'b01, 16'h0010, 3, 0, 1'b1);
    // One-shot, length 2, request held then dropped and re-raised
    vt[5]  = fv(2'b01, 2'b00, 16'h0010, 2, 0, 16'h0010, 0, 8'h10, 2'b00);
    vt[6]  = fv(2'b01, 2'b00, 16'h0010, 2, 0, 16'h0011, 0, 8'h11, 2'b01);
    vt[7]  = iv(2'b01, 2'b00, 16'h0010, 2, 0, 1'b1);
    vt[8]  = iv(2'b01, 2'b00, 16'h0010, 2, 0, 1'b0);
    vt[9]  = iv(2'b00, 2'b00, 16'h0010, 2, 0, 1'b0);
    vt[10] = fv(2'b01, 2'b00, 16'h0010, 2, 0, 16'h0010, 0, 8'h10, 2'b00);
    vt[11] = iv(2'b00, 2'b00, 16'h0010, 2, 0, 1'b1);
    // Channel 1 looping, preempted by channel 0, then resumes from its start
    vt[12] = fv(2'b10, 2'b10, 16'h0010, 2, 4, 16'h0040, 1, 8'h40, 2'b00);
    vt[13] = fv(2'b10, 2'b10, 16'h0010, 2, 4, 16'h0041, 1, 8'h41, 2'b00);
    vt[14] = fv(2'b11, 2'b11, 16'h0010, 3, 4, 16'h0010, 0, 8'h10, 2'b00);
    vt[15] = fv(2'b11, 2'b11, 16'h0010, 3, 4, 16'h0011, 0, 8'h11, 2'b00);
    vt[16] = fv(2'b10, 2'b11, 16'h0010, 3, 4, 16'h0040, 1, 8'h40, 2'b00);
    vt[17] = fv(2'b10, 2'b11, 16'h0010, 3, 4, 16'h0041, 1, 8'h41, 2'b00);
    // Zero length disables the channel
    vt[18] = iv(2'b01, 2'b01, 16'h0010, 0, 4, 1'b1);
    vt[19] = iv(2'b01, 2'b01, 16'h0010, 0, 4, 1'b0);
    // Length shrunk below the current position ends (and here loops) the clip
    vt[20] = fv(2'b01, 2'b01, 16'h0010, 4, 0, 16'h0010, 0, 8'h10, 2'b00);
    vt[21] = fv(2'b01, 2'b01, 16'h0010, 4, 0, 16'h0011, 0, 8'h11, 2'b00);
    vt[22] = fv(2'b01, 2'b01, 16'h0010, 1, 0, 16'h0012, 0, 8'h12, 2'b00);
    vt[23] = fv(2'b01, 2'b01, 16'h0010, 1, 0, 16'h0010, 0, 8'h10, 2'b00);
    vt[24] = iv(2'b00, 2'b01, 16'h0010, 1, 0, 1'b1);
    // Address wraps modulo 2^16
    vt[25] = fv(2'b01, 2'b01, 16'hFFFF, 2, 0, 16'hFFFF, 0, 8'hFF, 2'b00);
    vt[26] = fv(2'b01, 2'b01, 16'hFFFF, 2, 0, 16'h0000, 0, 8'h00, 2'b00);
    vt[27] = iv(2'b00, 2'b01, 16'hFFFF, 2, 0, 1'b1);

    ch_req = '0; ch_loop = '0; ch_base = '0; ch_len = '0;
    system_reset = 1'b0;
    #2 system_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_reset("por");
    @(negedge clk) system_reset = 1'b0;
    ph = 0;

    for (int i = 0; i < 28; i++) begin
      ch_req  = vt[i].req;
      ch_loop = vt[i].loop;
      ch_base = {16'h0040, vt[i].base0};
      ch_len  = {vt[i].len1, vt[i].len0};
      to_tick();
      #1;
      chk($sformatf("v%0d busy", i), busy, vt[i].fetch);
      chk($sformatf("v%0d valid@tick+1", i), sample_valid, vt[i].v0);
      if (vt[i].fetch) begin
        chk($sformatf("v%0d rom_addr", i), rom_addr, vt[i].addr);
        chk($sformatf("v%0d active_ch", i), active_ch, vt[i].act);
      end
      edge1(); edge1(); #1;
      chk($sformatf("v%0d valid@tick+3", i), sample_valid, vt[i].fetch);
      chk($sformatf("v%0d sample_out", i), sample_out, vt[i].smp);
      edge1(); #1;
      chk($sformatf("v%0d ch_done", i), ch_done, vt[i].done);
      chk($sformatf("v%0d valid@tick+4", i), sample_valid, 1'b0);
    end

    // Reset between the last sample of a one-shot and its ch_done pulse.
    ch_req = 2'b01; ch_loop = 2'b00; ch_base = {16'h0040, 16'h0010}; ch_len = {16'd0, 16'd1};
    to_tick();
    edge1(); edge1();
    #3 system_reset = 1'b1;
    #1 chk_reset("midclip");
    edge1(); edge1(); #1;
    chk("midclip done held", ch_done, 2'b00);
    ch_req = 2'b00;
    @(negedge clk) system_reset = 1'b0;
    ph = 0;
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ch_done != 2'b00) hi++;
    end
    chk("no ch_done after reset", hi, 0);

    // Divider restarts from zero: first tick edge lands DIV edges after release.
    ch_req = 2'b10; ch_loop = 2'b10; ch_base = {16'h0040, 16'h0010}; ch_len = {16'd1, 16'd0};
    to_tick();
    #1;
    chk("post-reset rom_addr", rom_addr, 16'h0040);
    chk("post-reset busy", busy, 1'b1);

    // Steady 0x40: any 256 consecutive cycles hold exactly 64 high cycles.
    repeat (300) @(negedge clk);
    chk("hold sample 0x40", sample_out, 8'h40);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk("pwm duty 0x40", hi, 64);

    // Period start = rising edge of pwm_out; change level just after it.
    found = 1'b0;
    @(negedge clk) prev = pwm_out;
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (pwm_out && !prev) found = 1'b1;
      else prev = pwm_out;
    end
    chk("pwm period start seen", found, 1'b1);
    ch_base = {16'h0020, 16'h0010};
    hi = 1;
    for (int k = 0; k < 255; k++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk("new level sample_out", sample_out, 8'h20);
    chk("pwm duty unchanged mid-period", hi, 64);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk("pwm duty after wrap", hi, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
